// File: rtl/aes_cbc_host.sv
// ---------------------------------------------------------------------------
// aes_cbc_host
//   Host-side sequencer for a block cipher engine. It takes one input block at
//   a time, hands it to the engine with the message configuration, waits for
//   the engine result and returns that result on an output stream. Each engine
//   wait is guarded by a watchdog. After a timeout the rest of the message is
//   drained and discarded.
//
// Handshake rule (s_* and m_*): a beat transfers on a rising clk edge where
//   valid and ready are both high. A producer holds valid and its payload
//   stable until that transfer happens.
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   s_valid/s_ready            input block handshake
//   s_data/s_last              input block, last-of-message marker
//   cfg_key/iv/mode/enc        per-message configuration (sampled on block 1)
//   eng_run/eng_fin            engine start pulse / end-of-message pulse
//   eng_msg_in/key/iv/mode/enc registered engine operands
//   eng_ready/eng_result       engine completion strobe and result
//   m_valid/m_ready            output block handshake
//   m_data/m_last              result block, last-of-message marker
//   busy/err_timeout/blk_cnt   not-idle / sticky watchdog flag / block count
//   dbg_state                  current FSM state, for observation
// ---------------------------------------------------------------------------
module aes_cbc_host #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [127:0]     s_data,
  input  logic             s_last,
  input  logic [255:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_enc,
  output logic             eng_run,
  output logic             eng_fin,
  output logic [127:0]     eng_msg_in,
  output logic [255:0]     eng_key,
  output logic [127:0]     eng_iv,
  output logic [1:0]       eng_mode,
  output logic             eng_enc,
  input  logic             eng_ready,
  input  logic [127:0]     eng_result,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     m_data,
  output logic             m_last,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  // Watchdog wide enough to hold TIMEOUT_CYC-1 for any TIMEOUT_CYC >= 1.
  localparam int            WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  state_t          r_state;
  logic            r_first;   // next accepted block starts a new message
  logic            r_last;    // block in flight is the last of its message
  logic [WD_W-1:0] r_wd;

  // Decoded straight from the state register, so these change only on clk.
  assign s_ready   = (r_state == S_IDLE) || (r_state == S_DRAIN);
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
      r_wd        <= '0;
      eng_run     <= 1'b0;
      eng_fin     <= 1'b0;
      eng_msg_in  <= '0;
      eng_key     <= '0;
      eng_iv      <= '0;
      eng_mode    <= '0;
      eng_enc     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      err_timeout <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      // Both engine strobes are single-cycle pulses; they are raised on the
      // transition into the cycle where they must be visible.
      eng_run <= 1'b0;
      eng_fin <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            eng_msg_in <= s_data;
            r_last     <= s_last;
            if (r_first) begin
              eng_key     <= cfg_key;
              eng_iv      <= cfg_iv;
              eng_mode    <= cfg_mode;
              eng_enc     <= cfg_enc;
              err_timeout <= 1'b0;
              blk_cnt     <= '0;
            end
            r_first <= 1'b0;
            eng_run <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_wd    <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A ready seen in the expiry cycle still counts as success.
          if (eng_ready) begin
            r_state <= S_CAPT;
          end else if (r_wd == WD_MAX) begin
            err_timeout <= 1'b1;
            eng_fin     <= 1'b1;
            r_first     <= 1'b1;
            r_state     <= r_last ? S_IDLE : S_DRAIN;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        S_CAPT: begin
          m_data  <= eng_result;
          m_last  <= r_last;
          m_valid <= 1'b1;
          blk_cnt <= blk_cnt + CNT_W'(1);
          r_state <= S_OUT;
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_last) begin
              eng_fin <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FIN: begin
          r_first <= 1'b1;
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          // Remaining blocks of a timed-out message are swallowed unseen.
          if (s_valid && s_last) begin
            r_first <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_host.sv
// ---------------------------------------------------------------------------
// tb_aes_cbc_host
//   Drives messages into aes_cbc_host with a behavioural engine attached.
//   Expected output blocks are pushed when blocks are issued; a monitor pops
//   and compares them on every output transfer.
// ---------------------------------------------------------------------------
module tb_aes_cbc_host;

  localparam int TO    = 8;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [127:0]     s_data = '0;
  logic             s_last = 1'b0;
  logic [255:0]     cfg_key = '0;
  logic [127:0]     cfg_iv = '0;
  logic [1:0]       cfg_mode = '0;
  logic             cfg_enc = 1'b0;
  logic             eng_run, eng_fin;
  logic [127:0]     eng_msg_in;
  logic [255:0]     eng_key;
  logic [127:0]     eng_iv;
  logic [1:0]       eng_mode;
  logic             eng_enc;
  logic             eng_ready = 1'b0;
  logic [127:0]     eng_result = '0;
  logic             m_valid;
  logic             m_ready;
  logic [127:0]     m_data;
  logic             m_last;
  logic             busy, err_timeout;
  logic [CNT_W-1:0] blk_cnt;
  logic [2:0]       dbg_state;

  aes_cbc_host #(.TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_mode(cfg_mode), .cfg_enc(cfg_enc),
    .eng_run(eng_run), .eng_fin(eng_fin), .eng_msg_in(eng_msg_in),
    .eng_key(eng_key), .eng_iv(eng_iv), .eng_mode(eng_mode), .eng_enc(eng_enc),
    .eng_ready(eng_ready), .eng_result(eng_result),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_timeout(err_timeout), .blk_cnt(blk_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [128:0] exp_q[$];   // {last, data}

  int run_cnt = 0, fin_cnt = 0, out_cnt = 0, out_at_fin = 0;
  int cyc = 0, t_hs = -100, t_rdy = -100;
  logic prev_mv = 1'b0, prev_run = 1'b0;
  logic [127:0] last_run_iv = '0;

  int eng_dly = 1;          // engine response delay in cycles, 0 = never
  logic mr_main = 1'b1, mr_rand = 1'b0, mr_rnd = 1'b1;
  assign m_ready = mr_rand ? mr_rnd : mr_main;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stand-in cipher: any fixed mixing of all operands will do.
  function automatic logic [127:0] ref_f(input logic [127:0] d, input logic [255:0] k,
                                         input logic [127:0] iv, input logic [1:0] md,
                                         input logic en);
    return ((d ^ iv) + k[127:0]) ^ k[255:128] ^ {124'd0, md, en, 1'b1};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // All drives happen 1 time unit after the falling edge; the monitor samples
  // 3 units after it, i.e. with the values the next rising edge will see.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- engine model ----------------
  initial begin
    int d;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && eng_run) begin
        d = eng_dly;
        if (d > 0) begin
          repeat (d) @(negedge clk);
          #1;
          eng_ready  = 1'b1;
          eng_result = ref_f(eng_msg_in, eng_key, eng_iv, eng_mode, eng_enc);
          @(negedge clk);
          #1;
          eng_ready = 1'b0;
        end
      end
    end
  end

  // ---------------- random backpressure ----------------
  always begin
    @(negedge clk);
    #1;
    mr_rnd = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [128:0] e;
    @(negedge clk);
    #3;
    cyc++;
    if (rst_n) begin
      if (eng_run) begin
        run_cnt++;
        last_run_iv = eng_iv;
        if (!prev_run) chk("hs_to_run_lat", 256'(cyc - t_hs), 256'd1);
      end
      if (eng_fin) begin
        fin_cnt++;
        out_at_fin = out_cnt;
      end
      if (m_valid && !prev_mv) chk("rdy_to_mvalid_lat", 256'(cyc - t_rdy), 256'd2);
      if (eng_ready) t_rdy = cyc;
      if (s_valid && s_ready) t_hs = cyc;
      if (m_valid && m_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 256'(m_valid), 256'd0);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", 256'(m_data), 256'(e[127:0]));
          chk("m_last", 256'(m_last), 256'(e[128]));
        end
      end
      prev_mv  = m_valid;
      prev_run = eng_run;
    end else begin
      prev_mv  = 1'b0;
      prev_run = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_cfg();
    cfg_key  = {rnd128(), rnd128()};
    cfg_iv   = rnd128();
    cfg_mode = 2'($urandom_range(0, 3));
    cfg_enc  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_block(input logic [127:0] d, input logic lst);
    int t = 0;
    s_data  = d;
    s_last  = lst;
    s_valid = 1'b1;
    while (!s_ready && t < 400) begin
      tick();
      t++;
    end
    if (!s_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: s_ready got 0 expected 1");
    end
    tick();
    s_valid = 1'b0;
  endtask

  // Sends an n-block message; cfg is scrambled after block 1 so only the
  // first-block sample may reach the engine.
  task automatic send_msg(input int n, input int dly, input bit expect_out, input bit fix_iv);
    logic [255:0] k;
    logic [127:0] iv, d;
    logic [1:0]   md;
    logic         en, lst;
    new_cfg();
    if (fix_iv) cfg_iv = 128'h1;
    k = cfg_key; iv = cfg_iv; md = cfg_mode; en = cfg_enc;
    for (int i = 0; i < n; i++) begin
      d   = rnd128();
      lst = (i == n - 1);
      if (expect_out) exp_q.push_back({lst, ref_f(d, k, iv, md, en)});
      eng_dly = dly;
      send_block(d, lst);
      new_cfg();
    end
  endtask

  task automatic wait_fin(input int tgt);
    int t = 0;
    while (fin_cnt < tgt && t < 3000) begin
      tick();
      t++;
    end
    chk("fin_wait", 256'(fin_cnt >= tgt), 256'd1);
  endtask

  task automatic check_reset_vals();
    chk("rst_s_ready", 256'(s_ready), 256'd1);
    chk("rst_eng_run", 256'(eng_run), 256'd0);
    chk("rst_eng_fin", 256'(eng_fin), 256'd0);
    chk("rst_eng_msg_in", 256'(eng_msg_in), 256'd0);
    chk("rst_eng_key", eng_key, 256'd0);
    chk("rst_eng_iv", 256'(eng_iv), 256'd0);
    chk("rst_eng_mode", 256'(eng_mode), 256'd0);
    chk("rst_eng_enc", 256'(eng_enc), 256'd0);
    chk("rst_m_valid", 256'(m_valid), 256'd0);
    chk("rst_m_data", 256'(m_data), 256'd0);
    chk("rst_m_last", 256'(m_last), 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    chk("rst_err_timeout", 256'(err_timeout), 256'd0);
    chk("rst_blk_cnt", 256'(blk_cnt), 256'd0);
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #1_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    int r0, f0, o0, n;
    bit ok_data, ok_srdy, ok_norun, ok_mv;
    logic [127:0] d0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    rst_n = 1'b1;
    repeat (2) tick();

    // Three-block message, engine 5 cycles, m_ready high
    r0 = run_cnt; f0 = fin_cnt; o0 = out_cnt;
    send_msg(3, 5, 1'b1, 1'b0);
    wait_fin(f0 + 1);
    tick();
    chk("m3_runs", 256'(run_cnt - r0), 256'd3);
    chk("m3_outs", 256'(out_cnt - o0), 256'd3);
    chk("m3_fins", 256'(fin_cnt - f0), 256'd1);
    chk("m3_fin_after_out3", 256'(out_at_fin - o0), 256'd3);
    chk("m3_blk_cnt", 256'(blk_cnt), 256'd3);
    chk("m3_err", 256'(err_timeout), 256'd0);

    // Single block with iv = 1
    f0 = fin_cnt; o0 = out_cnt;
    send_msg(1, 3, 1'b1, 1'b1);
    wait_fin(f0 + 1);
    chk("iv1_eng_iv", 256'(last_run_iv), 256'd1);
    chk("iv1_fin_after_out", 256'(out_at_fin - o0), 256'd1);
    chk("iv1_blk_cnt", 256'(blk_cnt), 256'd1);

    // Output stall of 10 cycles
    mr_main = 1'b0;
    f0 = fin_cnt; o0 = out_cnt;
    send_msg(1, 4, 1'b1, 1'b0);
    n = 0;
    while (!m_valid && n < 100) begin tick(); n++; end
    chk("stall_mvalid_seen", 256'(m_valid), 256'd1);
    d0 = m_data; r0 = run_cnt;
    ok_data = 1; ok_srdy = 1; ok_norun = 1; ok_mv = 1;
    repeat (10) begin
      tick();
      if (m_data !== d0) ok_data = 0;
      if (s_ready !== 1'b0) ok_srdy = 0;
      if (eng_run !== 1'b0) ok_norun = 0;
      if (m_valid !== 1'b1) ok_mv = 0;
    end
    chk("stall_data_stable", 256'(ok_data), 256'd1);
    chk("stall_s_ready_low", 256'(ok_srdy), 256'd1);
    chk("stall_no_run", 256'(ok_norun), 256'd1);
    chk("stall_m_valid_held", 256'(ok_mv), 256'd1);
    chk("stall_no_out", 256'(out_cnt - o0), 256'd0);
    mr_main = 1'b1;
    tick();
    chk("stall_m_valid_clear", 256'(m_valid), 256'd0);
    chk("stall_out_done", 256'(out_cnt - o0), 256'd1);
    wait_fin(f0 + 1);

    // Timeout on block 1 of 3
    r0 = run_cnt; f0 = fin_cnt; o0 = out_cnt;
    send_msg(3, 0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("to_err", 256'(err_timeout), 256'd1);
    chk("to_fins", 256'(fin_cnt - f0), 256'd1);
    chk("to_runs", 256'(run_cnt - r0), 256'd1);
    chk("to_outs", 256'(out_cnt - o0), 256'd0);
    chk("to_idle", 256'(busy), 256'd0);
    f0 = fin_cnt;
    send_msg(1, 3, 1'b1, 1'b0);
    wait_fin(f0 + 1);
    chk("to_next_err_clr", 256'(err_timeout), 256'd0);

    // Ready one cycle too late: timeout, late ready ignored
    f0 = fin_cnt; o0 = out_cnt;
    send_msg(1, TO + 1, 1'b0, 1'b0);
    wait_fin(f0 + 1);
    repeat (4) tick();
    chk("late_err", 256'(err_timeout), 256'd1);
    chk("late_outs", 256'(out_cnt - o0), 256'd0);
    chk("late_ignored_idle", 256'(busy), 256'd0);

    // Ready in the expiry cycle: success
    f0 = fin_cnt; o0 = out_cnt;
    send_msg(1, TO, 1'b1, 1'b0);
    wait_fin(f0 + 1);
    chk("edge_err", 256'(err_timeout), 256'd0);
    chk("edge_outs", 256'(out_cnt - o0), 256'd1);

    // Randomized messages with random backpressure
    mr_rand = 1'b1;
    for (int m = 0; m < 6; m++) begin
      n  = $urandom_range(1, 4);
      f0 = fin_cnt;
      send_msg(n, $urandom_range(1, TO), 1'b1, 1'b0);
      wait_fin(f0 + 1);
      chk("rnd_blk_cnt", 256'(blk_cnt), 256'(n));
      chk("rnd_err", 256'(err_timeout), 256'd0);
    end
    mr_rand = 1'b0;
    mr_main = 1'b1;

    // Reset during WAIT of block 2
    begin
      logic [255:0] k;
      logic [127:0] iv, d1;
      logic [1:0] md;
      logic en;
      new_cfg();
      k = cfg_key; iv = cfg_iv; md = cfg_mode; en = cfg_enc;
      d1 = rnd128();
      f0 = fin_cnt; o0 = out_cnt; r0 = run_cnt;
      exp_q.push_back({1'b0, ref_f(d1, k, iv, md, en)});
      eng_dly = 3;
      send_block(d1, 1'b0);
      new_cfg();
      eng_dly = 0;
      send_block(rnd128(), 1'b0);
      repeat (4) tick();
      chk("mid_block2_running", 256'(run_cnt - r0), 256'd2);
      chk("mid_busy", 256'(busy), 256'd1);
      rst_n = 1'b0;
      tick();
      check_reset_vals();
      chk("mid_no_fin", 256'(fin_cnt - f0), 256'd0);
      chk("mid_outs", 256'(out_cnt - o0), 256'd1);
      chk("mid_q_empty", 256'(exp_q.size()), 256'd0);
      tick();
      rst_n = 1'b1;
      tick();
    end
    f0 = fin_cnt;
    send_msg(2, 4, 1'b1, 1'b0);
    wait_fin(f0 + 1);
    chk("post_rst_blk_cnt", 256'(blk_cnt), 256'd2);
    chk("post_rst_err", 256'(err_timeout), 256'd0);

    repeat (5) tick();
    chk("final_q_empty", 256'(exp_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
